// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-ported data memory.
// m0 (CPU MEM stage) normally wins. m1 (DMA/debug) is forced through after
// STARVE_MAX consecutive m0 grants that it waited behind. Each access takes
// three cycles: grant in IDLE, memory strobe in ACCESS, one-cycle ack in RESP.
// Misaligned or out-of-range addresses are answered with err and never reach
// the memory. Every memory-side output comes straight from a register.
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MEM_BYTES  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // requester 0: CPU MEM stage
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  // requester 1: DMA / debug
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  // data memory
  output logic        mem_write_o,
  output logic        mem_read_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam int          WCW       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e           state_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic             id_q;       // 1 = m1 owns the current access
  logic             we_q;
  logic             legal_q;
  logic             mem_write_q, mem_read_q;
  logic [31:0]      mem_addr_q, mem_data_q;
  logic             m0_ack_q, m0_err_q, m1_ack_q, m1_err_q;
  logic [31:0]      m0_rdata_q, m1_rdata_q;

  logic             starved;
  logic             gnt_any, gnt_m1;
  logic             sel_we, sel_legal;
  logic [31:0]      sel_addr, sel_wdata;
  logic [31:0]      rd_word;

  assign starved = (wait_cnt_q == WCW'(STARVE_MAX));

  // Pick the winner among the current requests and check its address.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here up front) so no latch is inferred.
    gnt_any   = m0_req_i | m1_req_i;
    gnt_m1    = m1_req_i & (~m0_req_i | starved);
    sel_we    = gnt_m1 ? m1_we_i    : m0_we_i;
    sel_addr  = gnt_m1 ? m1_addr_i  : m0_addr_i;
    sel_wdata = gnt_m1 ? m1_wdata_i : m0_wdata_i;
    sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);
  end

  // Read data returned to the owner: the memory word for a legal read, else 0.
  assign rd_word = (legal_q && !we_q) ? mem_data_i : 32'h0;

  // Access FSM; every output, including the memory strobes, is a register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from pre-edge values.
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      legal_q     <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      m0_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_ack_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m1_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            id_q        <= gnt_m1;
            we_q        <= sel_we;
            legal_q     <= sel_legal;
            mem_write_q <= sel_legal &  sel_we;
            mem_read_q  <= sel_legal & ~sel_we;
            mem_addr_q  <= sel_legal ? sel_addr : 32'h0;
            mem_data_q  <= (sel_legal && sel_we) ? sel_wdata : 32'h0;
            // m1 losing while it waits counts toward starvation.
            if (gnt_m1) begin
              wait_cnt_q <= '0;
            end else if (m1_req_i && !starved) begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_addr_q  <= '0;
          mem_data_q  <= '0;
          if (id_q) begin
            m1_ack_q   <= 1'b1;
            m1_err_q   <= ~legal_q;
            m1_rdata_q <= rd_word;
          end else begin
            m0_ack_q   <= 1'b1;
            m0_err_q   <= ~legal_q;
            m0_rdata_q <= rd_word;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_write_o = mem_write_q;
  assign mem_read_o  = mem_read_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign m0_ack_o    = m0_ack_q;
  assign m0_err_o    = m0_err_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_ack_o    = m1_ack_q;
  assign m1_err_o    = m1_err_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule
